// File: rtl/int_to_half_convert.sv
// 32-bit integer to IEEE-754 half converter (FCVT.H.W / FCVT.H.WU).
// Normalises one bit per cycle, then rounds to nearest even in a single cycle.
package int_to_half_pkg;
    localparam int HALF_EXPONENT_W = 5;
    localparam int HALF_FRACTION_W = 10;

    typedef enum logic [2:0] {
        FUNCT_H_W  = 3'd0,
        FUNCT_H_WU = 3'd1,
        FUNCT_W_H  = 3'd2,
        FUNCT_WU_H = 3'd3
    } fpu_cvt_type_t;
endpackage

// state | meaning
// IDLE  | waiting for an operand, in_ready high
// NORM  | shifting magnitude left until its MSB reaches the top bit
// ROUND | extract fraction, round to nearest even, detect overflow
// DONE  | result presented, out_valid high until out_ready
module int_to_half_convert
    import int_to_half_pkg::*;
#(
    parameter int INT_WIDTH      = 32,
    parameter int EXPONENT_WIDTH = HALF_EXPONENT_W,
    parameter int FRACTION_WIDTH = HALF_FRACTION_W,
    parameter int BIAS           = 15
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INT_WIDTH-1:0] in,
    input  fpu_cvt_type_t        cvt_type,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out,
    output logic                 flag_nx,
    output logic                 flag_of
);
    localparam int CNT_W  = $clog2(INT_WIDTH);
    localparam int HALF_W = 1 + EXPONENT_WIDTH + FRACTION_WIDTH;
    localparam int GRD    = INT_WIDTH - 2 - FRACTION_WIDTH;
    localparam logic [7:0] EXP_MAX = 8'((1 << EXPONENT_WIDTH) - 1);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t                r_state;
    logic                  r_sign;
    logic [INT_WIDTH-1:0]  r_mag;
    logic [CNT_W-1:0]      r_cnt;
    logic [31:0]           r_out;
    logic                  r_nx;
    logic                  r_of;

    logic                      w_supported;
    logic                      w_neg;
    logic [INT_WIDTH-1:0]      w_abs;
    logic [FRACTION_WIDTH-1:0] w_frac;
    logic                      w_guard;
    logic                      w_sticky;
    logic                      w_round_up;
    logic [FRACTION_WIDTH:0]   w_frac_sum;
    logic [7:0]                w_exp;
    logic                      w_overflow;

    assign w_supported = (cvt_type == FUNCT_H_W) || (cvt_type == FUNCT_H_WU);
    assign w_neg       = (cvt_type == FUNCT_H_W) && in[INT_WIDTH-1];
    // Two's complement negate also maps the most negative value onto itself, which is its true magnitude.
    assign w_abs       = w_neg ? (~in + 1'b1) : in;

    assign w_frac     = r_mag[INT_WIDTH-2 -: FRACTION_WIDTH];
    assign w_guard    = r_mag[GRD];
    assign w_sticky   = |r_mag[GRD-1:0];
    assign w_round_up = w_guard && (w_sticky || w_frac[0]);
    assign w_frac_sum = {1'b0, w_frac} + {{FRACTION_WIDTH{1'b0}}, w_round_up};
    assign w_exp      = 8'(BIAS) + 8'(r_cnt) + {7'd0, w_frac_sum[FRACTION_WIDTH]};
    assign w_overflow = (w_exp >= EXP_MAX);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_sign  <= 1'b0;
            r_mag   <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_nx    <= 1'b0;
            r_of    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sign <= w_neg;
                        r_mag  <= w_abs;
                        r_cnt  <= CNT_W'(INT_WIDTH - 1);
                        if (!w_supported || (w_abs == '0)) begin
                            r_out   <= '0;
                            r_nx    <= 1'b0;
                            r_of    <= 1'b0;
                            r_state <= DONE;
                        end else begin
                            r_state <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (r_mag[INT_WIDTH-1]) begin
                        r_state <= ROUND;
                    end else begin
                        r_mag <= r_mag << 1;
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ROUND: begin
                    if (w_overflow) begin
                        r_out <= 32'({r_sign, {EXPONENT_WIDTH{1'b1}}, {FRACTION_WIDTH{1'b0}}});
                        r_nx  <= 1'b1;
                        r_of  <= 1'b1;
                    end else begin
                        r_out <= 32'(HALF_W'({r_sign, w_exp[EXPONENT_WIDTH-1:0],
                                               w_frac_sum[FRACTION_WIDTH-1:0]}));
                        r_nx  <= w_guard || w_sticky;
                        r_of  <= 1'b0;
                    end
                    r_state <= DONE;
                end
                DONE: begin
                    if (out_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out       = r_out;
    assign flag_nx   = r_nx;
    assign flag_of   = r_of;

endmodule

// File: tb/tb_int_to_half_convert.sv
// Self-checking bench for int_to_half_convert: vector table, corner sequences
// and randomized operands against an arithmetic reference model.
module tb_int_to_half_convert;
    import int_to_half_pkg::*;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_op = '0;
    fpu_cvt_type_t cvt_type = FUNCT_H_W;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out;
    logic          flag_nx;
    logic          flag_of;

    int n_cmp = 0;
    int n_mis = 0;

    int_to_half_convert dut (
        .CLK(CLK), .nRST(nRST),
        .in_valid(in_valid), .in_ready(in_ready), .in(in_op), .cvt_type(cvt_type),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .flag_nx(flag_nx), .flag_of(flag_of)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: value = q * 2^(e-10) with q in [1024,2047], remainder rounded to nearest even.
    function automatic void model(input logic [31:0] v, input fpu_cvt_type_t t,
                                  output logic [15:0] o, output logic nx,
                                  output logic of, output int lat);
        longint m, q, rem, half;
        int e;
        bit s;
        o = 16'h0; nx = 1'b0; of = 1'b0; lat = 1;
        if (t != FUNCT_H_W && t != FUNCT_H_WU) return;
        s = (t == FUNCT_H_W) && v[31];
        m = s ? -longint'($signed(v)) : longint'(v);
        if (m == 0) return;
        e = 0;
        while ((m >> (e + 1)) != 0) e++;
        lat = 3 + 31 - e;
        if (e <= 10) begin
            q = m << (10 - e); rem = 0; half = 1;
        end else begin
            q = m >> (e - 10);
            rem = m - (q << (e - 10));
            half = longint'(1) << (e - 11);
        end
        if (rem > half || (rem == half && (q % 2) == 1)) q++;
        if (q == 2048) begin q = 1024; e++; end
        if (e + 15 >= 31) begin
            o = s ? 16'hFC00 : 16'h7C00; nx = 1'b1; of = 1'b1;
        end else begin
            o = {s, 5'(e + 15), 10'(q - 1024)};
            nx = (rem != 0);
        end
    endfunction

    task automatic wait_valid(input string name, output int lat);
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge CLK); #1;
            lat++;
        end
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
    endtask

    task automatic run_op(input string name, input logic [31:0] v, input fpu_cvt_type_t t,
                          input logic [15:0] eo, input logic enx, input logic eof, input int elat);
        int lat;
        @(negedge CLK);
        chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_op = v; cvt_type = t; out_ready = 1'b0;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        wait_valid(name, lat);
        if (elat >= 0) chk({name, "_latency"}, 32'(lat), 32'(elat));
        chk({name, "_out"}, out, {16'h0, eo});
        chk({name, "_nx"}, 32'(flag_nx), 32'(enx));
        chk({name, "_of"}, 32'(flag_of), 32'(eof));
        @(negedge CLK);
        out_ready = 1'b1;
        @(posedge CLK); #1;
        chk({name, "_ready_after"}, 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    typedef struct {
        string         name;
        logic [31:0]   val;
        fpu_cvt_type_t ty;
        logic [15:0]   eo;
        logic          enx;
        logic          eof;
        int            elat;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [15:0] mo;
        logic mnx, mof;
        int mlat, lat;
        logic [31:0] v, held;
        fpu_cvt_type_t t;

        vecs[0]  = '{"one",      32'h00000001, FUNCT_H_W,  16'h3C00, 1'b0, 1'b0, 34};
        vecs[1]  = '{"neg_two",  32'hFFFFFFFE, FUNCT_H_W,  16'hC000, 1'b0, 1'b0, 33};
        vecs[2]  = '{"tie_even", 32'd2049,     FUNCT_H_W,  16'h6800, 1'b1, 1'b0, 23};
        vecs[3]  = '{"tie_up",   32'd2051,     FUNCT_H_W,  16'h6802, 1'b1, 1'b0, 23};
        vecs[4]  = '{"exact",    32'd2048,     FUNCT_H_W,  16'h6800, 1'b0, 1'b0, 23};
        vecs[5]  = '{"max_fin",  32'd65519,    FUNCT_H_W,  16'h7BFF, 1'b1, 1'b0, 19};
        vecs[6]  = '{"rnd_ovf",  32'd65520,    FUNCT_H_W,  16'h7C00, 1'b1, 1'b1, 19};
        vecs[7]  = '{"u_max",    32'hFFFFFFFF, FUNCT_H_WU, 16'h7C00, 1'b1, 1'b1, 3};
        vecs[8]  = '{"int_min",  32'h80000000, FUNCT_H_W,  16'hFC00, 1'b1, 1'b1, 3};
        vecs[9]  = '{"zero",     32'h00000000, FUNCT_H_W,  16'h0000, 1'b0, 1'b0, 1};
        vecs[10] = '{"unsupp",   32'h00000005, FUNCT_W_H,  16'h0000, 1'b0, 1'b0, 1};
        vecs[11] = '{"u_neg",    32'hFFFFFFFE, FUNCT_H_WU, 16'h7C00, 1'b1, 1'b1, 3};

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_out", out, 32'h0);
        chk("rst_nx", 32'(flag_nx), 32'd0);
        chk("rst_of", 32'(flag_of), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge CLK);
        nRST = 1'b1;

        for (int i = 0; i < 12; i++)
            run_op(vecs[i].name, vecs[i].val, vecs[i].ty, vecs[i].eo,
                   vecs[i].enx, vecs[i].eof, vecs[i].elat);

        // Backpressure: result held while a new operand waits
        @(negedge CLK);
        in_valid = 1'b1; in_op = 32'd5; cvt_type = FUNCT_H_W; out_ready = 1'b0;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        wait_valid("bp_first", lat);
        @(negedge CLK);
        in_valid = 1'b1; in_op = 32'd7;
        model(32'd5, FUNCT_H_W, mo, mnx, mof, mlat);
        held = out;
        chk("bp_first_out", held, {16'h0, mo});
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            chk("bp_hold_out", out, held);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge CLK);
        out_ready = 1'b1;
        @(posedge CLK); #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        chk("bp_accepted", 32'(in_ready), 32'd0);
        wait_valid("bp_second", lat);
        model(32'd7, FUNCT_H_W, mo, mnx, mof, mlat);
        chk("bp_second_out", out, {16'h0, mo});
        chk("bp_second_latency", 32'(lat), 32'(mlat));
        @(negedge CLK);
        out_ready = 1'b1;
        @(posedge CLK); #1;
        out_ready = 1'b0;

        // Asynchronous reset in the middle of normalisation
        @(negedge CLK);
        in_valid = 1'b1; in_op = 32'd1; cvt_type = FUNCT_H_W;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out", out, 32'h0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge CLK);
        nRST = 1'b1;
        run_op("after_rst", 32'd3, FUNCT_H_W, 16'h4200, 1'b0, 1'b0, 33);

        for (int i = 0; i < 150; i++) begin
            v = $urandom() >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) v = -v;
            case ($urandom_range(0, 9))
                0:       t = FUNCT_WU_H;
                1, 2, 3: t = FUNCT_H_WU;
                default: t = FUNCT_H_W;
            endcase
            model(v, t, mo, mnx, mof, mlat);
            run_op("rand", v, t, mo, mnx, mof, mlat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
